// File: rtl/t_flip_flop_behav.sv
// Behavioural bank of WIDTH independent toggle flip-flops with synchronous clear and preset.
// Latency: 1 cycle from sampled clr/pst/t to q; q_bar is combinational from q.
// Backpressure: none; every rising edge of clk updates every bit.
//
// Ports:
//   clk    rising-edge clock
//   clr    per-bit synchronous clear, active-high, highest priority
//   pst    per-bit synchronous preset, active-high, below clr
//   t      per-bit toggle enable
//   q      registered state
//   q_bar  complement of q
//
// There is deliberately no power-up value: q stays X until an edge with
// clr or pst asserted on that bit.
module t_flip_flop_behav #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] clr,
  input  logic [WIDTH-1:0] pst,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  // Each bit is evaluated on its own; there is no coupling between bits.
  // Priority per bit: clear, then preset, then toggle, else hold.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (clr[i]) begin
        q[i] <= 1'b0;
      end else if (pst[i]) begin
        q[i] <= 1'b1;
      end else if (t[i]) begin
        q[i] <= ~q[i];
      end
    end
  end

  // Derived from q rather than stored separately so the pair can never agree.
  assign q_bar = ~q;

endmodule

// File: tb/tb_t_flip_flop_behav.sv
module tb_t_flip_flop_behav;

  localparam int W = 4;

  logic         clk;
  logic [W-1:0] clr;
  logic [W-1:0] pst;
  logic [W-1:0] t;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb[$];

  t_flip_flop_behav #(.WIDTH(W)) dut (
    .clk   (clk),
    .clr   (clr),
    .pst   (pst),
    .t     (t),
    .q     (q),
    .q_bar (q_bar)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] clr;
    logic [W-1:0] pst;
    logic [W-1:0] t;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic [W-1:0] c, input logic [W-1:0] p,
                     input logic [W-1:0] tt, input logic [W-1:0] e);
    vec_t v;
    v.name = name; v.clr = c; v.pst = p; v.t = tt; v.exp_q = e;
    vecs.push_back(v);
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic check_pop(input string name);
    logic [W-1:0] e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, q=%b", name, q);
    end else begin
      e = sb.pop_front();
      if (q !== e || q_bar !== ~e) begin
        errors++;
        $display("FAIL %s: q=%b q_bar=%b, expected q=%b q_bar=%b", name, q, q_bar, e, ~e);
      end
    end
  endtask

  // Drive at the falling edge, push expectation, compare 1 time unit after the rising edge.
  task automatic apply(input string name, input logic [W-1:0] c, input logic [W-1:0] p,
                       input logic [W-1:0] tt, input logic [W-1:0] e);
    @(negedge clk);
    clr = c; pst = p; t = tt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_pop(name);
  endtask

  logic [W-1:0] ref_q;
  logic [W-1:0] t_seq[6];

  initial begin
    clr = '0; pst = '0; t = '0;

    // Clear from X, hold
    add("clr_from_x",  4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add("hold0_a",     4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add("hold0_b",     4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add("hold0_c",     4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Preset, hold
    add("preset",      4'b0000, 4'b1111, 4'b0000, 4'b1111);
    add("hold1_a",     4'b0000, 4'b0000, 4'b0000, 4'b1111);
    add("hold1_b",     4'b0000, 4'b0000, 4'b0000, 4'b1111);
    // Toggle run from 0
    add("clr_run",     4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add("tog1",        4'b0000, 4'b0000, 4'b1111, 4'b1111);
    add("tog2",        4'b0000, 4'b0000, 4'b1111, 4'b0000);
    add("tog3",        4'b0000, 4'b0000, 4'b1111, 4'b1111);
    add("tog4",        4'b0000, 4'b0000, 4'b1111, 4'b0000);
    add("tog5",        4'b0000, 4'b0000, 4'b1111, 4'b1111);
    add("tog6",        4'b0000, 4'b0000, 4'b1111, 4'b0000);
    // Priority: clr over pst over t
    add("prio_setup",  4'b0000, 4'b1111, 4'b0000, 4'b1111);
    add("prio_all",    4'b1111, 4'b1111, 4'b1111, 4'b0000);
    add("prio_pst",    4'b0000, 4'b1111, 4'b0000, 4'b1111);
    add("prio_tog",    4'b0000, 4'b0000, 4'b1111, 4'b0000);
    // Preset released with t=1 in the same cycle
    add("pst_with_t",  4'b0000, 4'b1111, 4'b1111, 4'b1111);
    add("after_pst_t", 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    // Bit independence
    add("ind_clr",     4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add("ind_t0101",   4'b0000, 4'b0000, 4'b0101, 4'b0101);
    add("ind_clr1000", 4'b1000, 4'b0000, 4'b0101, 4'b0000);
    add("ind_mixed",   4'b0001, 4'b0010, 4'b0100, 4'b0110);
    add("ind_cp_tog",  4'b0110, 4'b0110, 4'b1001, 4'b1001);
    // Clear in the middle of a toggle run, then resume from 0
    add("mid_tog",     4'b0000, 4'b0000, 4'b1111, 4'b0110);
    add("mid_clr",     4'b1111, 4'b0000, 4'b1111, 4'b0000);
    add("mid_resume",  4'b0000, 4'b0000, 4'b1111, 4'b1111);

    foreach (vecs[i]) apply(vecs[i].name, vecs[i].clr, vecs[i].pst, vecs[i].t, vecs[i].exp_q);

    // Glitch on clr/pst between rising edges must be ignored (q currently 1111)
    @(negedge clk);
    clr = '0; pst = '0; t = '0;
    #2 clr = 4'b1111;
    #5 clr = 4'b0000;
    sb.push_back(4'b1111);
    @(posedge clk);
    #1;
    check_pop("clr_glitch");
    @(negedge clk);
    #2 pst = 4'b0000; t = 4'b0000; clr = 4'b0000;
    apply("pre_pst_glitch", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    #2 pst = 4'b1111;
    #5 pst = 4'b0000;
    sb.push_back(4'b0000);
    @(posedge clk);
    #1;
    check_pop("pst_glitch");

    // Alternating t, held 50 units each against a 20-unit clock (q is 0000 here)
    t_seq[0] = 4'b0000; t_seq[1] = 4'b1111; t_seq[2] = 4'b0000;
    t_seq[3] = 4'b1111; t_seq[4] = 4'b0000; t_seq[5] = 4'b1111;
    ref_q = 4'b0000;
    @(negedge clk);
    clr = '0; pst = '0;
    fork
      begin
        // Offset so t changes never coincide with a rising edge
        #5;
        for (int k = 0; k < 6; k++) begin
          t = t_seq[k];
          #50;
        end
        t = '0;
      end
      begin
        for (int k = 0; k < 15; k++) begin
          @(posedge clk);
          ref_q = ref_q ^ t;
          sb.push_back(ref_q);
          #1;
          check_pop("alt_t");
        end
      end
    join

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound the run regardless of what the DUT does
  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/t_flip_flop_behav.md
# t_flip_flop_behav

Behavioural toggle (T) flip-flop with synchronous preset and clear, parameterised as a bank of WIDTH independent bits. Each bit holds its state when its t input is 0 and inverts it on the rising clock edge when t is 1. Complementary outputs are provided. It is the reference storage element for counters and frequency dividers in the latch/flip-flop library, and is paired with a gate-level twin of identical port list.

## Interface
One clock; reset is synchronous and active-high.

Parameters:
- WIDTH, 1, number of independent T flip-flop bits (legal 1..64)

Ports:
- clk  input  1  rising-edge clock; the only clock
- clr  input  WIDTH  synchronous active-high clear (reset), per bit
- pst  input  WIDTH  synchronous active-high preset, per bit
- t  input  WIDTH  toggle enable, per bit
- q  output  WIDTH  stored state, registered
- q_bar  output  WIDTH  combinational complement of q

## Operation
- Per bit i, evaluated at each rising edge of clk, in priority order:
  - clr[i]=1 -> q[i] <= 0
  - else pst[i]=1 -> q[i] <= 1
  - else t[i]=1 -> q[i] <= ~q[i]
  - else q[i] holds
- When clr[i] and pst[i] are asserted in the same cycle, clr wins (q[i]=0). There is no illegal-state handling.
- q_bar = ~q at all times, including during clear and preset. The pair is never equal.
- Bits are fully independent. There is no carry or coupling between bits.
- No asynchronous paths: clr, pst and t changing between edges have no effect on q.
- Power-up state is undefined (X in simulation) until the first edge with clr or pst asserted. The design has no initial value; users must clear or preset before relying on q.

## Timing
- Latency: 1 cycle. Inputs sampled at edge n appear on q after edge n.
- Reset values: after any edge with clr=1, q=0 and q_bar=1. After pst=1 (clr=0), q=1 and q_bar=0.
- Toggle: with t=1 held for N edges, q inverts at every edge. The result is a square wave at clk/2. After N edges q equals its start value XOR (N mod 2).
- Reset mid-operation: asserting clr during a toggle run forces 0 at that edge regardless of t. Toggling resumes from 0 on the first edge after clr deasserts with t=1.
- Preset released with t=1 in the same cycle: the release edge loads 1. The next edge toggles to 0.
- One-cycle pulses on clr or pst (one full clk period straddling an edge) must take effect. Pulses that do not cover a rising edge are ignored.

## Test plan
- Clear: clr=1 for one edge from X state, t=0 -> q=0, q_bar=1. Hold t=0 for 3 edges -> q stays 0.
- Preset: clr=0, pst=1 for one edge -> q=1, q_bar=0. Then pst=0, t=0 for 2 edges -> q holds 1.
- Toggle run: from q=0, t=1 for 6 edges -> q sequence 1,0,1,0,1,0. q_bar is always the complement.
- Alternating t (period 50 time units vs clk period 20): t=0,1,0,1,0,1 each held 50 -> q changes only on edges where t=1. Check q against a reference model at each sample.
- Priority: clr=1, pst=1, t=1 on the same edge with q=1 -> q=0. Next edge with clr=0, pst=1 -> q=1. Next edge with pst=0, t=1 -> q=0.
- WIDTH=4 independence: q=0000, t=0101, then clr=1000 on the next edge -> q=0101 after the first edge and 0000 after the second. Bits 1 and 3 ignore neighbouring controls.
